cp0_exc_ctrl: RTL and testbench

//   Write-side initiator for the CP0 register file: sequences exception/interrupt entry and ERET return.
//   - One CP0 write per cycle; CP0 read port is combinational.
//   - Sits between the pipeline control and CP0.
//   - Entry: snapshots Status, writes EPC, Cause, then Status, and redirects fetch to the vector.
//   - ERET: reads EPC, clears EXL and redirects to EPC.

---
 rtl/cp0_exc_ctrl_if.sv | 25 ++
 rtl/cp0_exc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_ctrl_if.sv
// CP0 register-file access bus: one write port and one combinational read port.
// The exception controller is the master; the CP0 register file is the slave.
interface cp0_exc_ctrl_if;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic [4:0]  cp0_raddr;
   logic [31:0] cp0_rdata;

   modport master (
      output cp0_we,
      output cp0_waddr,
      output cp0_wdata,
      output cp0_raddr,
      input  cp0_rdata
   );

   modport slave (
      input  cp0_we,
      input  cp0_waddr,
      input  cp0_wdata,
      input  cp0_raddr,
      output cp0_rdata
   );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt entry and ERET sequencer; drives one CP0 write per cycle.
// Optional EXC_IRQ_SYNC_EN: irq passes a 2-flop synchronizer before use.
module cp0_exc_ctrl #(
   parameter logic [31:0] VECTOR_ADDR = 32'h0000_0008,
   parameter logic [4:0]  STATUS_ADDR = 5'd12,
   parameter logic [4:0]  CAUSE_ADDR  = 5'd13,
   parameter logic [4:0]  EPC_ADDR    = 5'd14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exc_req,
   input  logic [4:0]            exc_code,
   input  logic [31:0]           exc_pc,
   input  logic [31:0]           cur_pc,
   input  logic [5:0]            irq,
   input  logic                  eret,
   cp0_exc_ctrl_if.master        cp0,
   output logic                  stall,
   output logic                  redirect,
   output logic [31:0]           redirect_pc
);

   typedef enum logic [2:0] {
      IDLE,
      W_EPC,
      W_CAUSE,
      W_STATUS,
      E_RD,
      E_STATUS,
      REDIR
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] stat_q;
   logic [31:0] epc_q;
   logic [5:0]  ip_q;
   logic [4:0]  code_q;
   logic        ret_q;
   logic [5:0]  irq_s;
   logic        int_ok;

`ifdef EXC_IRQ_SYNC_EN
   logic [5:0] irq_m;

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_m <= '0;
         irq_s <= '0;
      end else begin
         irq_m <= irq;
         irq_s <= irq_m;
      end
   end
`else
   assign irq_s = irq;
`endif

   // In IDLE the read port shows Status, so rdata is the live Status word here.
   assign int_ok = cp0.cp0_rdata[0] & ~cp0.cp0_rdata[1]
                 & (|(irq_s & cp0.cp0_rdata[15:10]));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (exc_req || int_ok) state_d = W_EPC;
            else if (eret)         state_d = E_RD;
         end
         W_EPC:    state_d = W_CAUSE;
         W_CAUSE:  state_d = W_STATUS;
         W_STATUS: state_d = REDIR;
         E_RD:     state_d = E_STATUS;
         E_STATUS: state_d = REDIR;
         REDIR:    state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // NOTE: these are a handful of control registers, not a memory, so all of them are reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_q <= '0;
         epc_q  <= '0;
         ip_q   <= '0;
         code_q <= '0;
         ret_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (exc_req) begin
                  stat_q <= cp0.cp0_rdata;
                  ip_q   <= irq_s;
                  code_q <= exc_code;
                  epc_q  <= exc_pc;
                  ret_q  <= 1'b0;
               end else if (int_ok) begin
                  stat_q <= cp0.cp0_rdata;
                  ip_q   <= irq_s;
                  code_q <= '0;
                  epc_q  <= cur_pc;
                  ret_q  <= 1'b0;
               end else if (eret) begin
                  stat_q <= cp0.cp0_rdata;
                  ip_q   <= irq_s;
                  ret_q  <= 1'b1;
               end
            end
            E_RD:    epc_q <= cp0.cp0_rdata;
            default: ;
         endcase
      end
   end

   assign stall = (state_q != IDLE);

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      cp0.cp0_we    = 1'b0;
      cp0.cp0_waddr = '0;
      cp0.cp0_wdata = '0;
      cp0.cp0_raddr = STATUS_ADDR;
      redirect      = 1'b0;
      redirect_pc   = '0;
      case (state_q)
         W_EPC: begin
            cp0.cp0_we    = 1'b1;
            cp0.cp0_waddr = EPC_ADDR;
            cp0.cp0_wdata = epc_q;
         end
         W_CAUSE: begin
            cp0.cp0_we    = 1'b1;
            cp0.cp0_waddr = CAUSE_ADDR;
            cp0.cp0_wdata = {16'b0, ip_q, 3'b0, code_q, 2'b0};
         end
         W_STATUS: begin
            cp0.cp0_we    = 1'b1;
            cp0.cp0_waddr = STATUS_ADDR;
            cp0.cp0_wdata = stat_q | 32'h0000_0002;
         end
         E_RD: cp0.cp0_raddr = EPC_ADDR;
         E_STATUS: begin
            cp0.cp0_we    = 1'b1;
            cp0.cp0_waddr = STATUS_ADDR;
            cp0.cp0_wdata = stat_q & ~32'h0000_0002;
         end
         REDIR: begin
            redirect    = 1'b1;
            redirect_pc = ret_q ? epc_q : VECTOR_ADDR;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: a CP0 register-file model, a scoreboard of expected
// CP0 writes / redirects, and directed per-cycle stall and latency checks.
module tb_cp0_exc_ctrl;

`ifdef EXC_IRQ_SYNC_EN
   localparam int IRQ_LAT = 3;
`else
   localparam int IRQ_LAT = 1;
`endif
   // Simultaneous request case: irq only reaches ip_q when it is not synchronized.
   localparam logic [31:0] T5_CAUSE = (IRQ_LAT == 1) ? 32'h0000_0410 : 32'h0000_0010;

   typedef struct packed {
      logic        redir;
      logic [4:0]  addr;
      logic [31:0] data;
   } ev_t;

   logic        clk;
   logic        rst;
   logic        exc_req;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic [31:0] cur_pc;
   logic [5:0]  irq;
   logic        eret;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic        bd_we;
   logic [4:0]  bd_addr;
   logic [31:0] bd_data;
   logic [31:0] regs [32];

   ev_t exp_q[$];
   ev_t mon_e;
   int  total = 0;
   int  bad   = 0;

   cp0_exc_ctrl_if bus ();

   cp0_exc_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .exc_req     (exc_req),
      .exc_code    (exc_code),
      .exc_pc      (exc_pc),
      .cur_pc      (cur_pc),
      .irq         (irq),
      .eret        (eret),
      .cp0         (bus),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CP0 register file model with a bench-side write port for test setup.
   assign bus.cp0_rdata = regs[bus.cp0_raddr];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         if (bus.cp0_we) regs[bus.cp0_waddr] <= bus.cp0_wdata;
         if (bd_we)      regs[bd_addr]       <= bd_data;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back('{1'b0, a, d});
   endtask

   task automatic expect_redir(input logic [31:0] pc);
      exp_q.push_back('{1'b1, 5'd0, pc});
   endtask

   // Scoreboard monitor: every CP0 write or redirect pulse must match the next expected event.
   always @(negedge clk) begin
      if (!rst && (bus.cp0_we || redirect)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected output: we=%b waddr=%0d wdata=%h redirect=%b pc=%h, none expected",
                     bus.cp0_we, bus.cp0_waddr, bus.cp0_wdata, redirect, redirect_pc);
         end else begin
            mon_e = exp_q.pop_front();
            check("mon kind(redirect)", {31'b0, redirect}, {31'b0, mon_e.redir});
            if (mon_e.redir) begin
               check("mon redirect_pc", redirect_pc, mon_e.data);
            end else begin
               check("mon waddr", {27'b0, bus.cp0_waddr}, {27'b0, mon_e.addr});
               check("mon wdata", bus.cp0_wdata, mon_e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = d;
      tick();
      bd_we   = 1'b0;
   endtask

   task automatic idle_check(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({name, " stall"}, {31'b0, stall}, 32'd0);
         tick();
      end
   endtask

   // Called just after a posedge with requests driven; returns at the negedge of cycle 1.
   task automatic wait_accept(input string name, input int exp_lat);
      int  lat;
      bit  found;
      lat   = 99;
      found = 1'b0;
      for (int i = 1; i <= 10 && !found; i++) begin
         @(negedge clk);
         if (stall) begin
            found = 1'b1;
            lat   = i - 1;
         end
      end
      check({name, " accept latency"}, lat, exp_lat);
   endtask

   // Starts at the negedge of cycle 1; checks stall/redirect per cycle, then the drop of stall.
   task automatic check_seq(input string name, input int n, input bit is_eret);
      for (int i = 1; i <= n; i++) begin
         if (i > 1) @(negedge clk);
         check({name, " stall"}, {31'b0, stall}, 32'd1);
         check({name, " redirect"}, {31'b0, redirect}, (i == n) ? 32'd1 : 32'd0);
         if (is_eret && i == 1) check({name, " raddr"}, {27'b0, bus.cp0_raddr}, 32'd14);
      end
      exc_req = 1'b0;
      eret    = 1'b0;
      @(negedge clk);
      check({name, " stall after"}, {31'b0, stall}, 32'd0);
      tick();
   endtask

   initial begin
      rst      = 1'b1;
      exc_req  = 1'b0;
      exc_code = '0;
      exc_pc   = '0;
      cur_pc   = '0;
      irq      = '0;
      eret     = 1'b0;
      bd_we    = 1'b0;
      bd_addr  = '0;
      bd_data  = '0;

      // 1. reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst cp0_we", {31'b0, bus.cp0_we}, 32'd0);
      check("rst cp0_waddr", {27'b0, bus.cp0_waddr}, 32'd0);
      check("rst cp0_wdata", bus.cp0_wdata, 32'd0);
      check("rst cp0_raddr", {27'b0, bus.cp0_raddr}, 32'd12);
      check("rst stall", {31'b0, stall}, 32'd0);
      check("rst redirect", {31'b0, redirect}, 32'd0);
      check("rst redirect_pc", redirect_pc, 32'd0);
      tick();
      rst = 1'b0;
      idle_check("post-rst", 2);

      // 2. synchronous exception, exc_req held until stall drops
      set_reg(5'd12, 32'h0000_FC01);
      expect_wr(5'd14, 32'h0000_0040);
      expect_wr(5'd13, 32'h0000_0020);
      expect_wr(5'd12, 32'h0000_FC03);
      expect_redir(32'h0000_0008);
      exc_req  = 1'b1;
      exc_code = 5'd8;
      exc_pc   = 32'h0000_0040;
      wait_accept("exc", 1);
      check_seq("exc", 4, 1'b0);

      // 3a. masked (IM=0) and 3b. EXL=1: irq never accepted
      set_reg(5'd12, 32'h0000_0001);
      irq = 6'b000001;
      idle_check("irq IM=0", 6);
      set_reg(5'd12, 32'h0000_0403);
      idle_check("irq EXL=1", 6);
      irq = '0;
      idle_check("irq flush", 3);

      // 3c. enabled interrupt; irq dropped right after accept
      set_reg(5'd12, 32'h0000_0401);
      expect_wr(5'd14, 32'h0000_0100);
      expect_wr(5'd13, 32'h0000_0400);
      expect_wr(5'd12, 32'h0000_0403);
      expect_redir(32'h0000_0008);
      cur_pc = 32'h0000_0100;
      irq    = 6'b000001;
      wait_accept("irq", IRQ_LAT);
      irq = '0;
      check_seq("irq", 4, 1'b0);
      idle_check("irq flush2", 3);

      // 4. ERET back to the saved EPC
      expect_wr(5'd12, 32'h0000_0401);
      expect_redir(32'h0000_0100);
      eret = 1'b1;
      wait_accept("eret", 1);
      check_seq("eret", 3, 1'b1);

      // 5. exc_req + irq + eret together: exception wins, irq then blocked by EXL
      expect_wr(5'd14, 32'h0000_0200);
      expect_wr(5'd13, T5_CAUSE);
      expect_wr(5'd12, 32'h0000_0403);
      expect_redir(32'h0000_0008);
      exc_req  = 1'b1;
      exc_code = 5'd4;
      exc_pc   = 32'h0000_0200;
      irq      = 6'b000001;
      eret     = 1'b1;
      wait_accept("simul", 1);
      exc_req = 1'b0;
      eret    = 1'b0;
      check_seq("simul", 4, 1'b0);
      idle_check("simul irq held", 6);
      irq = '0;
      idle_check("simul flush", 3);

      // 6. exception with EXL=1 is still taken; rst lands in W_CAUSE
      expect_wr(5'd14, 32'h0000_0300);
      exc_req  = 1'b1;
      exc_code = 5'd12;
      exc_pc   = 32'h0000_0300;
      wait_accept("rst-mid", 1);
      exc_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("rst-mid cp0_we", {31'b0, bus.cp0_we}, 32'd0);
      check("rst-mid cp0_waddr", {27'b0, bus.cp0_waddr}, 32'd0);
      check("rst-mid stall", {31'b0, stall}, 32'd0);
      check("rst-mid redirect", {31'b0, redirect}, 32'd0);
      tick();
      rst = 1'b0;
      idle_check("rst-mid after", 5);

      @(negedge clk);
      check("scoreboard drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
